// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and enums for the decoder and the program loader.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Encodings 6 and 7 are deliberately left out; they mark an illegal beat.
  typedef enum logic [2:0] {
    K_RTYPE = 3'd0,
    K_LW    = 3'd1,
    K_SW    = 3'd2,
    K_BEQ   = 3'd3,
    K_ADDI  = 3'd4,
    K_JUMP  = 3'd5
  } instr_kind_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction kind plus fields into one 32-bit MIPS word.
module instr_pack
  import mips_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (kind_i)
      K_RTYPE: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
      K_LW:    word_o = {OP_LW,    rs_i, rt_i, imm_i};
      K_SW:    word_o = {OP_SW,    rs_i, rt_i, imm_i};
      K_BEQ:   word_o = {OP_BEQ,   rs_i, rt_i, imm_i};
      K_ADDI:  word_o = {OP_ADDI,  rs_i, rt_i, imm_i};
      K_JUMP:  word_o = {OP_J,     target_i};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs instruction beats and writes them to sequential imem words.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0]   CAP    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  load_state_t       state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wd_q, wd_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [31:0]       packWord;
  logic              packIllegal;
  logic              accept;

  instr_pack uPack (
    .kind_i    (kind),
    .rs_i      (rs),
    .rt_i      (rt),
    .rd_i      (rd),
    .shamt_i   (shamt),
    .funct_i   (funct),
    .imm_i     (imm),
    .target_i  (target),
    .word_o    (packWord),
    .illegal_o (packIllegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // start overrides everything; finish only matters while loading
  always_comb begin
    state_d = state_q;
    if (start)                             state_d = S_LOAD;
    else if (finish && state_q == S_LOAD)  state_d = S_DONE;
  end

  always_comb begin
    full     = (count_q == CAP);
    in_ready = (state_q == S_LOAD) && !full && !start;
    busy     = (state_q == S_LOAD);
  end

  assign accept = in_valid && in_ready;

  // Accepted legal beats are captured into the write register and advance
  // the address/count; illegal beats are swallowed and only raise err.
  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    err_d   = err_q;
    if (start) begin
      count_d = '0;
      addr_d  = BASE_A;
      err_d   = 1'b0;
    end else if (accept) begin
      if (packIllegal) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wd_d    = packWord;
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      addr_q  <= BASE_A;
      waddr_q <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign imem_we   = we_q;
  assign imem_addr = waddr_q;
  assign imem_wd   = wd_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench: two loaders (64-word and 4-word) against a behavioural model.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, finish, in_valid;
  logic [2:0]  kind;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  logic        rdy0, we0, full0, busy0, err0;
  logic [5:0]  addr0;
  logic [31:0] wd0;
  logic [6:0]  cnt0;
  logic        rdyS, weS, fullS, busyS, errS;
  logic [1:0]  addrS;
  logic [31:0] wdS;
  logic [2:0]  cntS;

  instr_encoder #(.ADDR_W(6), .BASE(0)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(rdy0), .kind(kind), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .imem_we(we0), .imem_addr(addr0), .imem_wd(wd0), .count(cnt0),
    .full(full0), .busy(busy0), .err(err0)
  );

  instr_encoder #(.ADDR_W(2), .BASE(0)) dutS (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(rdyS), .kind(kind), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .imem_we(weS), .imem_addr(addrS), .imem_wd(wdS), .count(cntS),
    .full(fullS), .busy(busyS), .err(errS)
  );

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: mode 0 idle, 1 loading, 2 done; index 0 is the 64-word loader, 1 the 4-word one
  int          cap [2] = '{64, 4};
  int          mMode [2];
  int          mCnt [2];
  int          mNext [2];
  bit          mErr [2];
  bit          mWe [2];
  int          mAddr [2];
  logic [31:0] mWd [2];
  logic [31:0] modelMem [2][64];
  bit          modelWritten [2][64];
  logic [31:0] dutMem [2][64];

  typedef struct { int a; logic [31:0] d; } wr_t;
  wr_t log0[$];

  function automatic logic [31:0] mipsWord(input int k);
    case (k)
      0: return {6'h00, rs, rt, rd, shamt, funct};
      1: return {6'h23, rs, rt, imm};
      2: return {6'h2B, rs, rt, imm};
      3: return {6'h04, rs, rt, imm};
      4: return {6'h08, rs, rt, imm};
      default: return {6'h02, target};
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mMode[k] = 0; mCnt[k] = 0; mNext[k] = 0; mErr[k] = 0;
        mWe[k] = 0; mAddr[k] = 0; mWd[k] = '0;
      end else begin
        bit ready;
        ready = (mMode[k] == 1) && (mCnt[k] < cap[k]) && !start;
        mWe[k] = 0;
        if (start) begin
          mMode[k] = 1; mCnt[k] = 0; mNext[k] = 0; mErr[k] = 0;
        end else begin
          if (in_valid && ready) begin
            if (int'(kind) > 5) mErr[k] = 1;
            else begin
              mWe[k] = 1;
              mAddr[k] = mNext[k];
              mWd[k] = mipsWord(int'(kind));
              modelMem[k][mNext[k]] = mWd[k];
              modelWritten[k][mNext[k]] = 1;
              mNext[k] = (mNext[k] + 1) % cap[k];
              mCnt[k]++;
            end
          end
          if (finish && mMode[k] == 1) mMode[k] = 2;
        end
      end
    end
  end

  task automatic checkInst(input int k, input bit we, input int addr, input logic [31:0] wd,
                           input int cnt, input bit fl, input bit bsy, input bit er, input bit rdy);
    checkOutput($sformatf("imem_we[%0d]", k), we, mWe[k]);
    if (mWe[k]) begin
      checkOutput($sformatf("imem_addr[%0d]", k), addr, mAddr[k]);
      checkOutput($sformatf("imem_wd[%0d]", k), wd, mWd[k]);
    end
    checkOutput($sformatf("count[%0d]", k), cnt, mCnt[k]);
    checkOutput($sformatf("full[%0d]", k), fl, mCnt[k] == cap[k]);
    checkOutput($sformatf("busy[%0d]", k), bsy, mMode[k] == 1);
    checkOutput($sformatf("err[%0d]", k), er, mErr[k]);
    checkOutput($sformatf("in_ready[%0d]", k), rdy,
                (mMode[k] == 1) && (mCnt[k] < cap[k]) && !start);
  endtask

  always @(negedge clk) begin
    checkInst(0, we0, int'(addr0), wd0, int'(cnt0), full0, busy0, err0, rdy0);
    checkInst(1, weS, int'(addrS), wdS, int'(cntS), fullS, busyS, errS, rdyS);
    if (we0) begin
      dutMem[0][addr0] = wd0;
      log0.push_back('{int'(addr0), wd0});
    end
    if (weS) dutMem[1][addrS] = wdS;
  end

  // Called just after a rising edge; holds the inputs for one edge, then drops pulses.
  task automatic applyStimulus(input bit s, input bit f, input bit v, input int k,
                               input int rsV, input int rtV, input int rdV, input int shV,
                               input int fuV, input int immV, input int tgV);
    start = s; finish = f; in_valid = v; kind = 3'(k);
    rs = 5'(rsV); rt = 5'(rtV); rd = 5'(rdV); shamt = 5'(shV);
    funct = 6'(fuV); imm = 16'(immV); target = 26'(tgV);
    @(posedge clk); #1;
    start = 0; finish = 0; in_valid = 0;
  endtask

  task automatic beat(input int k, input int rsV, input int rtV, input int immV);
    applyStimulus(0, 0, 1, k, rsV, rtV, 0, 0, 0, immV, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulseStart();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkLog(input int idx, input int a, input logic [31:0] d);
    if (idx < log0.size()) begin
      checkOutput($sformatf("log%0d_addr", idx), log0[idx].a, a);
      checkOutput($sformatf("log%0d_word", idx), log0[idx].d, d);
    end else begin
      checkOutput($sformatf("log%0d_present", idx), log0.size(), idx + 1);
    end
  endtask

  initial begin
    int n;
    reset = 1; start = 0; finish = 0; in_valid = 0; kind = 0;
    rs = 0; rt = 0; rd = 0; shamt = 0; funct = 0; imm = 0; target = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_we", we0, 0);
    checkOutput("reset_count", cnt0, 0);
    checkOutput("reset_busy", busy0, 0);
    checkOutput("reset_ready", rdy0, 0);
    reset = 0;
    idle(1);

    $display("[TB] loads and stores");
    pulseStart();
    beat(4, 0, 8, 5);
    beat(1, 8, 9, 4);
    beat(2, 0, 9, 8);
    idle(2);
    checkLog(0, 0, 32'h20080005);
    checkLog(1, 1, 32'h8D090004);
    checkLog(2, 2, 32'hAC090008);
    checkOutput("count_after_three", cnt0, 3);

    $display("[TB] rtype, branch, jump");
    applyStimulus(0, 0, 1, 0, 8, 9, 10, 0, 6'b100000, 0, 0);
    beat(3, 8, 9, 2);
    applyStimulus(0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 26'h10);
    idle(2);
    checkLog(3, 3, 32'h01095020);
    checkLog(4, 4, 32'h11090002);
    checkLog(5, 5, 32'h08000010);

    $display("[TB] illegal kind");
    pulseStart();
    beat(4, 1, 2, 7);
    beat(6, 1, 2, 7);
    beat(4, 1, 3, 9);
    idle(3);
    checkOutput("err_sticky", err0, 1);
    checkLog(6, 0, 32'h20220007);
    checkLog(7, 1, 32'h20230009);
    pulseStart();
    checkOutput("err_cleared", err0, 0);

    $display("[TB] finish with a beat");
    beat(4, 0, 4, 1);
    applyStimulus(0, 1, 1, 4, 0, 5, 0, 0, 0, 2, 0);
    checkOutput("final_write_we", we0, 1);
    checkOutput("final_write_addr", addr0, 1);
    checkOutput("done_busy", busy0, 0);
    checkOutput("done_ready", rdy0, 0);
    n = log0.size();
    beat(4, 0, 6, 3);
    beat(4, 0, 7, 3);
    idle(1);
    checkOutput("done_no_writes", log0.size(), n + 1);
    pulseStart();
    checkOutput("restart_count", cnt0, 0);
    checkOutput("restart_busy", busy0, 1);
    beat(4, 0, 1, 1);
    checkOutput("restart_addr", addr0, 0);

    $display("[TB] small memory fills");
    pulseStart();
    for (int i = 1; i <= 5; i++) beat(4, 0, i, i);
    idle(1);
    checkOutput("small_full", fullS, 1);
    checkOutput("small_ready", rdyS, 0);
    checkOutput("small_count", cntS, 4);
    checkOutput("small_word0", dutMem[1][0], 32'h20010001);
    checkOutput("small_word3", dutMem[1][3], 32'h20040004);

    $display("[TB] reset mid-stream");
    pulseStart();
    beat(4, 0, 2, 2);
    checkOutput("pending_we", we0, 1);
    reset = 1;
    #1;
    checkOutput("async_we", we0, 0);
    checkOutput("async_addr", addr0, 0);
    checkOutput("async_wd", wd0, 0);
    checkOutput("async_count", cnt0, 0);
    checkOutput("async_busy", busy0, 0);
    @(posedge clk); #1;
    reset = 0;
    idle(1);
    applyStimulus(1, 0, 1, 4, 0, 3, 0, 0, 0, 3, 0);
    checkOutput("start_beat_we", we0, 0);
    checkOutput("start_beat_count", cnt0, 0);

    $display("[TB] random stream");
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom % 40) == 0, ($urandom % 30) == 0, ($urandom % 4) != 0,
                    int'($urandom % 8), int'($urandom), int'($urandom), int'($urandom),
                    int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    end
    idle(2);

    for (int k = 0; k < 2; k++)
      for (int a = 0; a < cap[k]; a++)
        if (modelWritten[k][a])
          checkOutput($sformatf("mem[%0d][%0d]", k, a), dutMem[k][a], modelMem[k][a]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Program-loader block that writes the instruction memory the main decoder reads. It accepts one instruction description per valid/ready beat (instruction kind plus register, immediate and target fields) and packs it into a 32-bit MIPS word. It writes each word to sequential imem word addresses. It sits between the testbench/boot source and the imem write port and is used to preload programs before the core leaves reset.

Parameters:
ADDR_W, 6, imem word-address width; capacity 2**ADDR_W words
BASE, 0, first word address written after start

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; clears counter and error, enters LOAD
finish  in  1  one-cycle pulse; ends load, enters DONE
in_valid  in  1  instruction beat valid
in_ready  out  1  block can accept a beat this cycle
kind  in  3  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 JUMP, 6-7 illegal
rs  in  5  source register
rt  in  5  second source / destination register
rd  in  5  R-type destination register
shamt  in  5  R-type shift amount
funct  in  6  R-type function code
imm  in  16  immediate / branch offset
target  in  26  jump target field
imem_we  out  1  imem write strobe
imem_addr  out  ADDR_W  imem word address
imem_wd  out  32  imem write data
count  out  ADDR_W+1  words written since start
full  out  1  count == 2**ADDR_W
busy  out  1  state == LOAD
err  out  1  sticky: illegal kind was presented

Behaviour:
- States: IDLE, LOAD, DONE.
- Reset (async) → IDLE. All outputs 0; internal address register = BASE.
- start in any state → LOAD next cycle. Also: count=0, address=BASE, err=0. Start has priority over every other input. in_ready is forced low in the start cycle, so no beat is accepted.
- finish in LOAD → DONE. finish in IDLE or DONE is ignored.
- If finish and an accepted beat occur in the same cycle, the beat is written, then the state is DONE.
- in_ready = (state==LOAD) && !full && !start.
- Accept = in_valid && in_ready.
- Packing of an accepted beat (opcodes are fixed):
  - RTYPE: {000000, rs, rt, rd, shamt, funct}
  - LW: {100011, rs, rt, imm}
  - SW: {101011, rs, rt, imm}
  - BEQ: {000100, rs, rt, imm}
  - ADDI: {001000, rs, rt, imm}
  - JUMP: {000010, target}
- Latency: accept in cycle N. In cycle N+1, imem_we=1 for exactly one cycle, with imem_addr/imem_wd registered from cycle N. The address then increments and count increments.
- Back-to-back accepts give one write per cycle at consecutive addresses.
- Address wraps modulo 2**ADDR_W. The count reaching 2**ADDR_W sets full and drops in_ready, so a wrap never overwrites data.
- Illegal kind (6, 7): the beat is consumed (handshake completes). Nothing is written, count and address are unchanged, and err is set and held until start or reset.
- imem_we = 0 in IDLE and DONE, except for the write of a beat accepted in the final LOAD cycle.
- Reset mid-LOAD: any pending write is dropped, and imem_we deasserts immediately (asynchronously).
- DONE holds count, full and err stable until start or reset.

Decomposition:
- Shared package mips_pkg holds:
  - the 6-bit opcode constants (OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_ADDI=001000, OP_J=000010), shared with the main decoder;
  - the instr_kind_t 3-bit enum;
  - the loader state enum.
- One combinational sub-module, instr_pack: kind plus fields → 32-bit word and an illegal flag.
- The top level holds the FSM, address/count registers and write register.

Test Plan:
1. reset; start (BASE=0); three beats: ADDI rs=0 rt=8 imm=5, LW rs=8 rt=9 imm=4, SW rs=0 rt=9 imm=8 → writes 0x20080005 @0, 0x8D090004 @1, 0xAC090008 @2. Each write is one cycle after accept. count=3.
2. RTYPE rs=8 rt=9 rd=10 shamt=0 funct=100000; BEQ rs=8 rt=9 imm=2; JUMP target=0x10 → 0x01095020, 0x11090002, 0x08000010 at consecutive addresses.
3. ADDR_W=2: stream 5 valid beats → 4 writes @0..3, full=1, in_ready=0. The 5th beat is held, not written, and address 0 is not overwritten.
4. kind=6 between two ADDI beats → illegal beat consumed with no write. err=1 and stays set. The next ADDI goes to the next address with no gap. A later start clears err.
5. finish together with an accepted beat → that word is written, state DONE, in_ready=0. Further in_valid produces no writes. start returns to LOAD with count=0, address=BASE.
6. Assert reset mid-stream with a write pending → imem_we drops immediately and all outputs are 0. start together with in_valid → beat not accepted that cycle.
